// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
// Contents: FSM state enum, CPU vector width, grant index width and the
// default source count / data width used by the top level.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } intc_state_t;

    localparam int unsigned INTC_VEC_W  = 16;
    // Wide enough for any source count up to 16.
    localparam int unsigned INTC_IDX_W  = 4;
    localparam int unsigned INTC_N_SRC  = 4;
    localparam int unsigned INTC_DATA_W = 16;

endpackage

// File: rtl/intc_arbiter.sv
// Winner select for the interrupt controller.
// Optional feature macro: INTC_ROUND_ROBIN_EN (round-robin search with a
// start pointer register); default is fixed lowest-index priority.
// Ports:
//   clk, rst_n, take  (round-robin build only) clock, async reset, grant taken
//   pending           masked interrupt requests
//   winner            index of the selected source
//   valid             at least one source is pending
module intc_arbiter
    import intc_pkg::*;
#(
    parameter int unsigned N_SRC = INTC_N_SRC
) (
`ifdef INTC_ROUND_ROBIN_EN
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  take,
`endif
    input  logic [N_SRC-1:0]      pending,
    output logic [INTC_IDX_W-1:0] winner,
    output logic                  valid
);

`ifdef INTC_ROUND_ROBIN_EN
    // ptr_q holds the first index to search, i.e. last_grant+1 mod N_SRC.
    logic [INTC_IDX_W-1:0] ptr_q;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (!valid && pending[j] && (j == (int'(ptr_q) + k) % N_SRC)) begin
                    winner = INTC_IDX_W'(j);
                    valid  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (take) begin
            ptr_q <= (winner == INTC_IDX_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        // Descending scan so the lowest pending index is assigned last.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner = INTC_IDX_W'(i);
                valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/intc_arbiter_ctrl.sv
// Interrupt controller: masks N_SRC level-interrupt sources, grants one,
// presents its index and data to the CPU and routes the CPU ack back.
// Optional feature macro: INTC_ROUND_ROBIN_EN (round-robin arbitration).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   src_int, src_data   per-source interrupt level and data word
//   src_ack             per-source acknowledge (one-hot or zero)
//   mask_we, mask_wdata mask register write; bit=1 blocks a source
//   mask_q              current mask
//   cpu_int, cpu_ack    CPU request / acknowledge
//   cpu_vector          granted index, zero-extended
//   cpu_data            data captured from the granted source
module intc_arbiter_ctrl
    import intc_pkg::*;
#(
    parameter int unsigned N_SRC  = INTC_N_SRC,
    parameter int unsigned DATA_W = INTC_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        src_int,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ack,
    input  logic                    mask_we,
    input  logic [N_SRC-1:0]        mask_wdata,
    output logic [N_SRC-1:0]        mask_q,
    output logic                    cpu_int,
    input  logic                    cpu_ack,
    output logic [INTC_VEC_W-1:0]   cpu_vector,
    output logic [DATA_W-1:0]       cpu_data
);

    intc_state_t           state_q, state_d;
    logic [INTC_IDX_W-1:0] gnt_q, gnt_d;
    logic                  cpu_int_q, cpu_int_d;
    logic [N_SRC-1:0]      src_ack_q, src_ack_d;
    logic [INTC_VEC_W-1:0] vec_q, vec_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [N_SRC-1:0]      mask_r;

    logic [N_SRC-1:0]      pending;
    logic [INTC_IDX_W-1:0] winner;
    logic                  valid;
    logic                  take;
    logic [DATA_W-1:0]     win_data;
    logic                  gnt_int;

    assign pending = src_int & ~mask_r;
    assign take    = (state_q == IDLE) && valid;

    intc_arbiter #(
        .N_SRC (N_SRC)
    ) u_arb (
`ifdef INTC_ROUND_ROBIN_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .take    (take),
`endif
        .pending (pending),
        .winner  (winner),
        .valid   (valid)
    );

    // Constant-index muxes keep the variable selects width-clean.
    always_comb begin
        win_data = '0;
        gnt_int  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (winner == INTC_IDX_W'(i)) win_data = src_data[i*DATA_W +: DATA_W];
            if (gnt_q == INTC_IDX_W'(i))  gnt_int  = src_int[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cpu_int_d = cpu_int_q;
        src_ack_d = src_ack_q;
        vec_d     = vec_q;
        data_d    = data_q;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d   = REQ;
                    gnt_d     = winner;
                    cpu_int_d = 1'b1;
                    vec_d     = {{(INTC_VEC_W - INTC_IDX_W){1'b0}}, winner};
                    data_d    = win_data;
                end
            end
            REQ: begin
                // Grant is committed: neither masking nor a source drop revokes it.
                if (cpu_ack) begin
                    state_d   = ACK;
                    cpu_int_d = 1'b0;
                    for (int i = 0; i < N_SRC; i++) begin
                        src_ack_d[i] = (gnt_q == INTC_IDX_W'(i));
                    end
                end
            end
            ACK: begin
                if (!gnt_int) begin
                    state_d   = IDLE;
                    src_ack_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                cpu_int_d = 1'b0;
                src_ack_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            cpu_int_q <= 1'b0;
            src_ack_q <= '0;
            vec_q     <= '0;
            data_q    <= '0;
            mask_r    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cpu_int_q <= cpu_int_d;
            src_ack_q <= src_ack_d;
            vec_q     <= vec_d;
            data_q    <= data_d;
            if (mask_we) mask_r <= mask_wdata;
        end
    end

    assign src_ack    = src_ack_q;
    assign mask_q     = mask_r;
    assign cpu_int    = cpu_int_q;
    assign cpu_vector = vec_q;
    assign cpu_data   = data_q;

endmodule

// File: tb/tb_intc_arbiter_ctrl.sv
module tb_intc_arbiter_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   src_int = '0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_ack;
    logic           mask_we = 1'b0;
    logic [N-1:0]   mask_wdata = '0;
    logic [N-1:0]   mask_q;
    logic           cpu_int;
    logic           cpu_ack = 1'b0;
    logic [15:0]    cpu_vector;
    logic [W-1:0]   cpu_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    intc_arbiter_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_int    (src_int),
        .src_data   (src_data),
        .src_ack    (src_ack),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_q     (mask_q),
        .cpu_int    (cpu_int),
        .cpu_ack    (cpu_ack),
        .cpu_vector (cpu_vector),
        .cpu_data   (cpu_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a transaction is "waiting for CPU" or "waiting for
    // the source to drop"; otherwise the controller is free to grant.
    int          m_phase;   // 0 free, 1 waiting cpu ack, 2 waiting source drop
    int          m_gnt;
    int          m_ptr;
    logic [N-1:0] m_mask;
    bit          m_int;
    logic [N-1:0] m_ack;
    int          m_vec;
    logic [W-1:0] m_data;

    function automatic int pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
`ifdef INTC_ROUND_ROBIN_EN
            if (p[(start + k) % N]) return (start + k) % N;
`else
            if (p[k]) return k;
`endif
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_gnt = 0; m_ptr = 0; m_mask = '0;
            m_int = 0; m_ack = '0; m_vec = 0; m_data = '0;
        end else begin
            case (m_phase)
                0: begin
                    int g;
                    g = pick(src_int & ~m_mask, m_ptr);
                    if (g >= 0) begin
                        m_gnt = g; m_vec = g; m_data = src_data[g*W +: W];
                        m_int = 1; m_phase = 1; m_ptr = (g + 1) % N;
                    end
                end
                1: if (cpu_ack) begin
                    m_int = 0; m_ack = '0; m_ack[m_gnt] = 1'b1; m_phase = 2;
                end
                default: if (!src_int[m_gnt]) begin
                    m_ack = '0; m_phase = 0;
                end
            endcase
            if (mask_we) m_mask = mask_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_cpu_int", 32'(cpu_int), 32'(m_int));
            chk("model_src_ack", 32'(src_ack), 32'(m_ack));
            chk("model_cpu_vector", 32'(cpu_vector), 32'(m_vec));
            chk("model_cpu_data", 32'(cpu_data), 32'(m_data));
            chk("model_mask_q", 32'(mask_q), 32'(m_mask));
        end
    end

    task automatic wait_grant(input int exp_vec, input logic [W-1:0] exp_data);
        for (int i = 0; i < 20; i++) begin
            if (cpu_int) break;
            @(negedge clk);
        end
        chk("grant_cpu_int", 32'(cpu_int), 32'd1);
        chk("grant_vector", 32'(cpu_vector), 32'(exp_vec));
        chk("grant_data", 32'(cpu_data), 32'(exp_data));
    endtask

    // CPU acks; the source drops one cycle after seeing src_ack.
    task automatic serve(input int b, input bit reassert);
        logic [N-1:0] oh;
        oh = '0;
        oh[b] = 1'b1;
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("serve_cpu_int_low", 32'(cpu_int), 32'd0);
        chk("serve_src_ack", 32'(src_ack), 32'(oh));
        src_int[b] = 1'b0;
        @(negedge clk);
        chk("serve_src_ack_clear", 32'(src_ack), 32'd0);
        if (reassert) src_int[b] = 1'b1;
    endtask

    initial begin
        src_data = {16'h4444, 16'hABCD, 16'h2222, 16'h1111};
        #12;
        chk("reset_cpu_int", 32'(cpu_int), 32'd0);
        chk("reset_mask_q", 32'(mask_q), 32'd0);
        chk("reset_vector", 32'(cpu_vector), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single source full handshake
        src_int = 4'b0100;
        wait_grant(2, 16'hABCD);
        @(negedge clk);
        chk("req_hold_int", 32'(cpu_int), 32'd1);
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("ack_src_ack", 32'(src_ack), 32'h4);
        chk("ack_cpu_int", 32'(cpu_int), 32'd0);
        repeat (2) @(negedge clk);
        chk("ack_hold", 32'(src_ack), 32'h4);
        src_int = 4'b0000;
        @(negedge clk);
        chk("ack_released", 32'(src_ack), 32'd0);
        chk("vector_kept", 32'(cpu_vector), 32'd2);
        @(negedge clk);

`ifndef INTC_ROUND_ROBIN_EN
        // Fixed priority with sources 1 and 3 pending
        src_int = 4'b1010;
        for (int t = 0; t < 3; t++) begin
            wait_grant(1, 16'h2222);
            serve(1, t < 2);
        end
        wait_grant(3, 16'h4444);
        serve(3, 1'b0);
        @(negedge clk);
`endif

        // Mask blocks source 0, unmask grants after the next edge
        mask_we = 1'b1; mask_wdata = 4'b0001;
        @(negedge clk);
        mask_we = 1'b0;
        src_int = 4'b0001;
        repeat (4) @(negedge clk);
        chk("masked_no_int", 32'(cpu_int), 32'd0);
        mask_we = 1'b1; mask_wdata = 4'b0000;
        @(negedge clk);
        mask_we = 1'b0;
        chk("unmask_edge_no_int", 32'(cpu_int), 32'd0);
        @(negedge clk);
        chk("unmask_grant_int", 32'(cpu_int), 32'd1);
        chk("unmask_grant_vec", 32'(cpu_vector), 32'd0);
        serve(0, 1'b0);
        @(negedge clk);

        // Ack outside REQ has no effect
        cpu_ack = 1'b1;
        repeat (3) @(negedge clk);
        cpu_ack = 1'b0;
        chk("idle_ack_src_ack", 32'(src_ack), 32'd0);
        chk("idle_ack_cpu_int", 32'(cpu_int), 32'd0);
        @(negedge clk);

        // Reset mid-REQ
        mask_we = 1'b1; mask_wdata = 4'b1000;
        @(negedge clk);
        mask_we = 1'b0;
        src_int = 4'b0010;
        wait_grant(1, 16'h2222);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cpu_int", 32'(cpu_int), 32'd0);
        chk("rst_src_ack", 32'(src_ack), 32'd0);
        chk("rst_vector", 32'(cpu_vector), 32'd0);
        chk("rst_data", 32'(cpu_data), 32'd0);
        chk("rst_mask", 32'(mask_q), 32'd0);
        src_int = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef INTC_ROUND_ROBIN_EN
        // Round robin with all sources held
        src_int = 4'b1111;
        wait_grant(0, 16'h1111); serve(0, 1'b1);
        wait_grant(1, 16'h2222); serve(1, 1'b1);
        wait_grant(2, 16'hABCD); serve(2, 1'b1);
        wait_grant(3, 16'h4444); serve(3, 1'b1);
        wait_grant(0, 16'h1111); serve(0, 1'b0);
        src_int = 4'b0000;
        repeat (4) @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
